// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-clock divider, H/V counters,
// frame-buffer fetch stage and a latency-matched registered output stage.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int COLOR_W   = 8,
  parameter int ADDR_W    = 10,
  parameter int PIX_DIV   = 1,
  parameter int RD_LAT    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [3*COLOR_W-1:0]   vga_data,
  output logic [ADDR_W-1:0]      h_addr,
  output logic [ADDR_W-1:0]      v_addr,
  output logic                   rd_en,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   valid,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   frame_start,
  output logic                   vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = 5;
  localparam int FLAG_W  = 5;
  localparam int F_ACT   = 0;
  localparam int F_HS    = 1;
  localparam int F_VS    = 2;
  localparam int F_FRM   = 3;
  localparam int F_VBL   = 4;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [ADDR_W-1:0] H_LAST   = ADDR_W'(H_TOTAL - 1);
  localparam logic [ADDR_W-1:0] V_LAST   = ADDR_W'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] H_ACT    = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] V_ACT    = ADDR_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] HS_BEG   = ADDR_W'(H_ACTIVE + H_FP);
  localparam logic [ADDR_W-1:0] HS_END   = ADDR_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [ADDR_W-1:0] VS_BEG   = ADDR_W'(V_ACTIVE + V_FP);
  localparam logic [ADDR_W-1:0] VS_END   = ADDR_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic              HS_ON    = (HSYNC_POL != 0);
  localparam logic              VS_ON    = (VSYNC_POL != 0);

  logic [DIV_W-1:0]     div_q, div_d;
  logic [ADDR_W-1:0]    hCnt_q, hCnt_d, vCnt_q, vCnt_d;
  logic [ADDR_W-1:0]    hAddr_q, hAddr_d, vAddr_q, vAddr_d;
  logic                 rdEn_q, rdEn_d;
  logic                 tick, pixActive;
  logic [FLAG_W-1:0]    curFlags, lastFlags;
  logic [FLAG_W-1:0]    pipe_q [0:RD_LAT];
  logic                 valid_q, valid_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic                 frameStart_q, frameStart_d, vblank_q, vblank_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;

  assign tick      = enable && (div_q == DIV_LAST);
  assign pixActive = (hCnt_q < H_ACT) && (vCnt_q < V_ACT);
  assign lastFlags = pipe_q[RD_LAT];

  // Classify the pixel the counters currently point at
  always_comb begin
    curFlags        = '0;
    curFlags[F_ACT] = pixActive;
    curFlags[F_HS]  = (hCnt_q >= HS_BEG) && (hCnt_q < HS_END);
    curFlags[F_VS]  = (vCnt_q >= VS_BEG) && (vCnt_q < VS_END);
    curFlags[F_FRM] = (hCnt_q == '0) && (vCnt_q == '0);
    curFlags[F_VBL] = (vCnt_q >= V_ACT);
  end

  // Divider and raster counters advance; disabling rewinds to pixel (0,0)
  always_comb begin
    div_d  = div_q;
    hCnt_d = hCnt_q;
    vCnt_d = vCnt_q;
    if (!enable) begin
      div_d  = '0;
      hCnt_d = '0;
      vCnt_d = '0;
    end else begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      if (tick) begin
        if (hCnt_q == H_LAST) begin
          hCnt_d = '0;
          vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 1'b1;
        end else begin
          hCnt_d = hCnt_q + 1'b1;
        end
      end
    end
  end

  // Fetch stage: strobe the frame buffer once per visible pixel tick, addresses held between ticks
  always_comb begin
    hAddr_d = hAddr_q;
    vAddr_d = vAddr_q;
    rdEn_d  = 1'b0;
    if (!enable) begin
      hAddr_d = '0;
      vAddr_d = '0;
    end else if (tick) begin
      rdEn_d  = pixActive;
      hAddr_d = pixActive ? hCnt_q : '0;
      vAddr_d = pixActive ? vCnt_q : '0;
    end
  end

  // Output stage: sample the flags that have aged RD_LAT ticks together with the returned data
  always_comb begin
    valid_d      = valid_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    vblank_d     = vblank_q;
    rgb_d        = rgb_q;
    frameStart_d = 1'b0;
    if (!enable) begin
      valid_d  = 1'b0;
      hsync_d  = ~HS_ON;
      vsync_d  = ~VS_ON;
      vblank_d = 1'b0;
      rgb_d    = '0;
    end else if (tick) begin
      valid_d      = lastFlags[F_ACT];
      hsync_d      = lastFlags[F_HS] ? HS_ON : ~HS_ON;
      vsync_d      = lastFlags[F_VS] ? VS_ON : ~VS_ON;
      vblank_d     = lastFlags[F_VBL];
      frameStart_d = lastFlags[F_FRM];
      rgb_d        = lastFlags[F_ACT] ? vga_data : '0;
    end
  end

  // Flag delay line matching the frame-buffer read latency, shifted once per tick
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= RD_LAT; i++) pipe_q[i] <= '0;
    end else if (!enable) begin
      for (int i = 0; i <= RD_LAT; i++) pipe_q[i] <= '0;
    end else if (tick) begin
      pipe_q[0] <= curFlags;
      for (int i = 1; i <= RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // State registers; reset drops every output to its idle level immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q        <= '0;
      hCnt_q       <= '0;
      vCnt_q       <= '0;
      hAddr_q      <= '0;
      vAddr_q      <= '0;
      rdEn_q       <= 1'b0;
      valid_q      <= 1'b0;
      hsync_q      <= ~HS_ON;
      vsync_q      <= ~VS_ON;
      vblank_q     <= 1'b0;
      frameStart_q <= 1'b0;
      rgb_q        <= '0;
    end else begin
      div_q        <= div_d;
      hCnt_q       <= hCnt_d;
      vCnt_q       <= vCnt_d;
      hAddr_q      <= hAddr_d;
      vAddr_q      <= vAddr_d;
      rdEn_q       <= rdEn_d;
      valid_q      <= valid_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      vblank_q     <= vblank_d;
      frameStart_q <= frameStart_d;
      rgb_q        <= rgb_d;
    end
  end

  assign h_addr      = hAddr_q;
  assign v_addr      = vAddr_q;
  assign rd_en       = rdEn_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign valid       = valid_q;
  assign vblank      = vblank_q;
  assign frame_start = frameStart_q;
  assign vga_r       = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign vga_g       = rgb_q[2*COLOR_W-1:COLOR_W];
  assign vga_b       = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: five instances cover default 640x480 timing,
// a 525-line narrow raster, a divided pixel clock, deeper read latency and inverted syncs.
module tb_vga_timing_gen;

  logic clock;
  logic resetA, reset;
  logic enA, enB, enC, enD, enE;
  logic [23:0] dataA, dataB, dataC, dataD, dataE;
  logic [9:0]  hAddrA, vAddrA, hAddrB, vAddrB, hAddrC, vAddrC, hAddrD, vAddrD, hAddrE, vAddrE;
  logic        rdEnA, rdEnB, rdEnC, rdEnD, rdEnE;
  logic        hsyncA, hsyncB, hsyncC, hsyncD, hsyncE;
  logic        vsyncA, vsyncB, vsyncC, vsyncD, vsyncE;
  logic        validA, validB, validC, validD, validE;
  logic [7:0]  rA, gA, bA, rB, gB, bB, rC, gC, bC, rD, gD, bD, rE, gE, bE;
  logic        frameStartA, frameStartB, frameStartC, frameStartD, frameStartE;
  logic        vblankA, vblankB, vblankC, vblankD, vblankE;
  logic [23:0] memD1, memD2;

  int checks, failures, n;
  int hsLow, hsFirst, vaCount, rgbErr, vbCount, vbFirst, vsLow, vsFirst;
  int hAt10, rdAt10, hAt638, rdAt638, fsAt800, vaAt800, vaAt1100, fsEnd, vbEnd;
  int pulseCount, firstFs, rgbAt19, hs4, hs5, vs31, vs32, rgbAt1;
  int pulseN [16];
  int pulseH [16];
  int pulseV [16];

  vga_timing_gen dutA (
    .clock(clock), .reset(resetA), .enable(enA), .vga_data(dataA),
    .h_addr(hAddrA), .v_addr(vAddrA), .rd_en(rdEnA), .hsync(hsyncA), .vsync(vsyncA),
    .valid(validA), .vga_r(rA), .vga_g(gA), .vga_b(bA), .frame_start(frameStartA), .vblank(vblankA));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1)) dutB (
    .clock(clock), .reset(reset), .enable(enB), .vga_data(dataB),
    .h_addr(hAddrB), .v_addr(vAddrB), .rd_en(rdEnB), .hsync(hsyncB), .vsync(vsyncB),
    .valid(validB), .vga_r(rB), .vga_g(gB), .vga_b(bB), .frame_start(frameStartB), .vblank(vblankB));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIX_DIV(3)) dutC (
    .clock(clock), .reset(reset), .enable(enC), .vga_data(dataC),
    .h_addr(hAddrC), .v_addr(vAddrC), .rd_en(rdEnC), .hsync(hsyncC), .vsync(vsyncC),
    .valid(validC), .vga_r(rC), .vga_g(gC), .vga_b(bC), .frame_start(frameStartC), .vblank(vblankC));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .RD_LAT(2)) dutD (
    .clock(clock), .reset(reset), .enable(enD), .vga_data(dataD),
    .h_addr(hAddrD), .v_addr(vAddrD), .rd_en(rdEnD), .hsync(hsyncD), .vsync(vsyncD),
    .valid(validD), .vga_r(rD), .vga_g(gD), .vga_b(bD), .frame_start(frameStartD), .vblank(vblankD));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .RD_LAT(0),
                   .HSYNC_POL(1), .VSYNC_POL(1)) dutE (
    .clock(clock), .reset(reset), .enable(enE), .vga_data(dataE),
    .h_addr(hAddrE), .v_addr(vAddrE), .rd_en(rdEnE), .hsync(hsyncE), .vsync(vsyncE),
    .valid(validE), .vga_r(rE), .vga_g(gE), .vga_b(bE), .frame_start(frameStartE), .vblank(vblankE));

  // Free-running system clock, 10 time units per period
  always #5 clock = ~clock;

  // Two-clock frame buffer model for the RD_LAT=2 instance, returning {h, v, h^v}
  always @(posedge clock) begin
    memD1 <= {hAddrD[7:0], vAddrD[7:0], hAddrD[7:0] ^ vAddrD[7:0]};
    memD2 <= memD1;
  end
  assign dataD = memD2;

  // Zero-latency frame buffer model for the RD_LAT=0 instance
  assign dataE = {hAddrE[7:0], vAddrE[7:0], 8'h5A};

  // Safety net so a stuck design can never hang the run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Directed sequence: one instance at a time, samples taken on the falling edge
  initial begin
    clock = 1'b0; resetA = 1'b1; reset = 1'b1;
    enA = 0; enB = 0; enC = 0; enD = 0; enE = 0;
    dataA = 24'hFF0000; dataB = 24'h00FF00; dataC = 24'h123456;
    checks = 0; failures = 0;
    for (int i = 0; i < 16; i++) begin pulseN[i] = 0; pulseH[i] = 0; pulseV[i] = 0; end

    #12;
    checkOutput("A reset hsync", hsyncA, 1);
    checkOutput("A reset vsync", vsyncA, 1);
    checkOutput("A reset valid", validA, 0);
    checkOutput("A reset rd_en", rdEnA, 0);
    checkOutput("A reset rgb", {rA, gA, bA}, 0);
    checkOutput("A reset vblank", vblankA, 0);
    checkOutput("E reset hsync", hsyncE, 0);
    checkOutput("E reset vsync", vsyncE, 0);

    // Default timing: one full line plus part of the next, with a red constant source
    @(negedge clock);
    resetA = 0; reset = 0; enA = 1;
    n = 0;
    do begin @(negedge clock); n++; end while (!frameStartA && n < 20);
    checkOutput("A frame_start latency", n, 3);
    hsLow = 0; hsFirst = -1; vaCount = 0; rgbErr = 0; vbCount = 0;
    for (int j = 0; j <= 1100; j++) begin
      if (j > 0) @(negedge clock);
      if (j < 800) begin
        if (!hsyncA) begin hsLow++; if (hsFirst < 0) hsFirst = j; end
        if (validA) vaCount++;
        if (validA ? ({rA, gA, bA} != 24'hFF0000) : ({rA, gA, bA} != 24'h0)) rgbErr++;
        if (vblankA) vbCount++;
      end
      if (j == 10)   begin hAt10 = int'(hAddrA); rdAt10 = int'(rdEnA); end
      if (j == 638)  begin hAt638 = int'(hAddrA); rdAt638 = int'(rdEnA); end
      if (j == 800)  begin fsAt800 = int'(frameStartA); vaAt800 = int'(validA); end
      if (j == 1100) vaAt1100 = int'(validA);
    end
    checkOutput("A hsync low ticks", hsLow, 96);
    checkOutput("A hsync first low h", hsFirst, 656);
    checkOutput("A valid ticks per line", vaCount, 640);
    checkOutput("A rgb blanking errors", rgbErr, 0);
    checkOutput("A vblank on line 0", vbCount, 0);
    checkOutput("A h_addr ahead of output", hAt10, 12);
    checkOutput("A rd_en active fetch", rdAt10, 1);
    checkOutput("A h_addr in blanking", hAt638, 0);
    checkOutput("A rd_en in blanking", rdAt638, 0);
    checkOutput("A no frame_start on line 1", fsAt800, 0);
    checkOutput("A valid at line 1 h0", vaAt800, 1);
    checkOutput("A valid at h300 line1", vaAt1100, 1);

    // Asynchronous reset in the middle of a visible line
    resetA = 1;
    #1;
    checkOutput("A midline reset valid", validA, 0);
    checkOutput("A midline reset hsync", hsyncA, 1);
    checkOutput("A midline reset rd_en", rdEnA, 0);
    checkOutput("A midline reset v_addr", vAddrA, 0);
    checkOutput("A midline reset rgb", {rA, gA, bA}, 0);
    @(negedge clock);
    resetA = 0;
    n = 0;
    do begin @(negedge clock); n++; end while (!frameStartA && n < 20);
    checkOutput("A restart frame_start latency", n, 3);
    enA = 0;

    // Narrow lines with the full 525-line vertical timing
    @(negedge clock);
    enB = 1;
    n = 0;
    do begin @(negedge clock); n++; end while (!frameStartB && n < 20);
    checkOutput("B frame_start seen", frameStartB, 1);
    vbCount = 0; vbFirst = -1; vsLow = 0; vsFirst = -1; vaCount = 0;
    for (int j = 0; j <= 4200; j++) begin
      if (j > 0) @(negedge clock);
      if (j < 4200) begin
        if (vblankB) begin vbCount++; if (vbFirst < 0) vbFirst = j; end
        if (!vsyncB) begin vsLow++; if (vsFirst < 0) vsFirst = j; end
        if (validB) vaCount++;
      end else begin
        fsEnd = int'(frameStartB);
        vbEnd = int'(vblankB);
      end
    end
    checkOutput("B vblank ticks", vbCount, 360);
    checkOutput("B vblank first tick", vbFirst, 3840);
    checkOutput("B vsync low ticks", vsLow, 16);
    checkOutput("B vsync first low tick", vsFirst, 3920);
    checkOutput("B valid ticks per frame", vaCount, 1920);
    checkOutput("B frame period 525 lines", fsEnd, 1);
    checkOutput("B vblank clear new frame", vbEnd, 0);
    enB = 0;

    // Divided pixel clock: fetch strobes three clocks apart, one frame window
    @(negedge clock);
    enC = 1;
    pulseCount = 0; firstFs = -1;
    for (int k = 1; k <= 144; k++) begin
      @(negedge clock);
      if (rdEnC) begin
        if (pulseCount < 16) begin
          pulseN[pulseCount] = k;
          pulseH[pulseCount] = int'(hAddrC);
          pulseV[pulseCount] = int'(vAddrC);
        end
        pulseCount++;
      end
      if (frameStartC && firstFs < 0) firstFs = k;
    end
    checkOutput("C rd_en pulses per frame", pulseCount, 12);
    checkOutput("C first rd_en clock", pulseN[0], 3);
    checkOutput("C pulse spacing 0-1", pulseN[1] - pulseN[0], 3);
    checkOutput("C pulse spacing 2-3", pulseN[3] - pulseN[2], 3);
    checkOutput("C pulse spacing across line", pulseN[4] - pulseN[3], 15);
    checkOutput("C h_addr second pulse", pulseH[1], 1);
    checkOutput("C v_addr fifth pulse", pulseV[4], 1);
    checkOutput("C h_addr fifth pulse", pulseH[4], 0);
    checkOutput("C frame_start clock", firstFs, 9);
    enC = 0;

    // Two-tick memory latency: each visible pixel must carry its own coordinates
    @(negedge clock);
    enD = 1;
    n = 0;
    do begin @(negedge clock); n++; end while (!frameStartD && n < 20);
    checkOutput("D frame_start latency", n, 4);
    rgbErr = 0; vaCount = 0; rgbAt19 = 0;
    for (int j = 0; j <= 96; j++) begin
      int h, v;
      logic expValid;
      if (j > 0) @(negedge clock);
      h = j % 8;
      v = (j / 8) % 6;
      expValid = (h < 4) && (v < 3);
      if (j < 96) begin
        if (validD !== expValid) rgbErr++;
        if (validD) begin
          vaCount++;
          if ({rD, gD, bD} !== {h[7:0], v[7:0], h[7:0] ^ v[7:0]}) rgbErr++;
        end else if ({rD, gD, bD} !== 24'h0) begin
          rgbErr++;
        end
        if (j == 19) rgbAt19 = int'({rD, gD, bD});
        if (j == 48) fsEnd = int'(frameStartD);
      end
    end
    checkOutput("D pixel data errors", rgbErr, 0);
    checkOutput("D valid count two frames", vaCount, 24);
    checkOutput("D rgb pixel (3,2)", rgbAt19, 24'h030201);
    checkOutput("D second frame_start", fsEnd, 1);
    enD = 0;

    // Active-high syncs, zero latency, enable dropped mid-frame and restarted
    @(negedge clock);
    enE = 1;
    n = 0;
    do begin @(negedge clock); n++; end while (!frameStartE && n < 20);
    checkOutput("E frame_start latency", n, 2);
    for (int j = 0; j <= 33; j++) begin
      if (j > 0) @(negedge clock);
      if (j == 1)  rgbAt1 = int'({rE, gE, bE});
      if (j == 4)  hs4 = int'(hsyncE);
      if (j == 5)  hs5 = int'(hsyncE);
      if (j == 31) vs31 = int'(vsyncE);
      if (j == 32) vs32 = int'(vsyncE);
    end
    checkOutput("E rgb pixel (1,0)", rgbAt1, 24'h01005A);
    checkOutput("E hsync before pulse", hs4, 0);
    checkOutput("E hsync pulse high", hs5, 1);
    checkOutput("E vsync before pulse", vs31, 0);
    checkOutput("E vsync pulse high", vs32, 1);
    checkOutput("E vsync high pre-disable", vsyncE, 1);
    enE = 0;
    @(negedge clock);
    checkOutput("E disable vsync idle", vsyncE, 0);
    checkOutput("E disable hsync idle", hsyncE, 0);
    checkOutput("E disable valid", validE, 0);
    checkOutput("E disable h_addr", hAddrE, 0);
    enE = 1;
    n = 0;
    do begin @(negedge clock); n++; end while (!frameStartE && n < 20);
    checkOutput("E re-enable frame_start latency", n, 2);
    checkOutput("E re-enable pixel (0,0)", {rE, gE, bE}, 24'h00005A);
    checkOutput("E re-enable valid", validE, 1);
    enE = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
